// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word; handshake gating and reset forcing happen in the top.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore decode of the controller state into the raw datapath control word.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Per-state control word; anything not named for a state stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic and
// output gating. Optional performance counters under MC_CTRL_PERF_CNT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------
// FETCH      | read instruction at PC, PC+4, wait for mem_ready
// DECODE     | opcode dispatch, branch target precompute
// MEMADR     | compute load/store address
// MEMRD      | load data read, wait for mem_ready
// MEMWB      | write load data to rt
// MEMWR      | store data write, wait for mem_ready
// EXECUTE    | R-type ALU operation
// ALUWB      | write ALU result to rd
// BRANCH     | beq compare, conditional PC load
// ADDIEXEC   | addi ALU operation
// ADDIWB     | write addi result to rt
// JUMP       | load jump target into PC
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
`ifdef MC_CTRL_PERF_CNT_EN
#(
  parameter int PERF_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic       busy_fetch
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] ret_cnt
`endif
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   in_fetch;
  logic   pcwrite_eff;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; memory states hold until the handshake completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // The fetch PC update and IR load only fire on the cycle memory returns
  // the instruction; the jump PC load is unconditional.
  assign in_fetch    = (state_q == S_FETCH);
  assign pcwrite_eff = ctrl.pcwrite & (~in_fetch | mem_ready);

  // Strobes are forced low while reset is held so nothing writes mid-reset.
  assign pcen       = rst_n & (pcwrite_eff | (ctrl.branch & zero));
  assign irwrite    = rst_n & ctrl.irwrite & mem_ready;
  assign memwrite   = rst_n & ctrl.memwrite;
  assign regwrite   = rst_n & ctrl.regwrite;
  assign illegal_op = rst_n & (state_q == S_DECODE) & ~op_supported(op);

  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign iord       = ctrl.iord;
  assign memtoreg   = ctrl.memtoreg;
  assign regdst     = ctrl.regdst;
  assign aluop      = ctrl.aluop;
  assign busy_fetch = in_fetch;

`ifdef MC_CTRL_PERF_CNT_EN
  // Cycle count and retired-instruction count (each return to FETCH).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + PERF_W'(1);
      if (!in_fetch && (state_d == S_FETCH)) ret_cnt <= ret_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm with an expected-value scoreboard.
// Build with MC_CTRL_PERF_CNT_EN to also cover the performance counters.
module tb_mc_ctrl_fsm;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic       illegal_op, busy_fetch;
  logic [1:0] alusrcb, pcsrc, aluop;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] sb_exp[$];
  string       sb_tag[$];

  mc_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .aluop      (aluop),
    .illegal_op (illegal_op),
    .busy_fetch (busy_fetch)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: pcen memwrite irwrite regwrite alusrca alusrcb pcsrc
  // iord memtoreg regdst aluop illegal_op busy_fetch
  function automatic logic [15:0] mk(input logic p, mw, ir, rw, sa, input logic [1:0] sb, ps,
                                     input logic io, mr, rd, input logic [1:0] ao,
                                     input logic il, bf);
    return {p, mw, ir, rw, sa, sb, ps, io, mr, rd, ao, il, bf};
  endfunction

  localparam logic [15:0] E_RST    = mk(0,0,0,0,0,2'b01,2'b00,0,0,0,2'b00,0,1);
  localparam logic [15:0] E_FWAIT  = mk(0,0,0,0,0,2'b01,2'b00,0,0,0,2'b00,0,1);
  localparam logic [15:0] E_FRDY   = mk(1,0,1,0,0,2'b01,2'b00,0,0,0,2'b00,0,1);
  localparam logic [15:0] E_DEC    = mk(0,0,0,0,0,2'b11,2'b00,0,0,0,2'b00,0,0);
  localparam logic [15:0] E_DECILL = mk(0,0,0,0,0,2'b11,2'b00,0,0,0,2'b00,1,0);
  localparam logic [15:0] E_MEMADR = mk(0,0,0,0,1,2'b10,2'b00,0,0,0,2'b00,0,0);
  localparam logic [15:0] E_MEMRD  = mk(0,0,0,0,0,2'b00,2'b00,1,0,0,2'b00,0,0);
  localparam logic [15:0] E_MEMWB  = mk(0,0,0,1,0,2'b00,2'b00,0,1,0,2'b00,0,0);
  localparam logic [15:0] E_MEMWR  = mk(0,1,0,0,0,2'b00,2'b00,1,0,0,2'b00,0,0);
  localparam logic [15:0] E_EXEC   = mk(0,0,0,0,1,2'b00,2'b00,0,0,0,2'b10,0,0);
  localparam logic [15:0] E_ALUWB  = mk(0,0,0,1,0,2'b00,2'b00,0,0,1,2'b00,0,0);
  localparam logic [15:0] E_BR_T   = mk(1,0,0,0,1,2'b00,2'b01,0,0,0,2'b01,0,0);
  localparam logic [15:0] E_BR_N   = mk(0,0,0,0,1,2'b00,2'b01,0,0,0,2'b01,0,0);
  localparam logic [15:0] E_ADDIEX = mk(0,0,0,0,1,2'b10,2'b00,0,0,0,2'b00,0,0);
  localparam logic [15:0] E_ADDIWB = mk(0,0,0,1,0,2'b00,2'b00,0,0,0,2'b00,0,0);
  localparam logic [15:0] E_JUMP   = mk(1,0,0,0,0,2'b00,2'b10,0,0,0,2'b00,0,0);

  logic [15:0] obs;
  assign obs = {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, pcsrc,
                iord, memtoreg, regdst, aluop, illegal_op, busy_fetch};

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic compare_head();
    logic [15:0] e;
    string       t;
    e = sb_exp.pop_front();
    t = sb_tag.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic check_now(input string tag, input logic [15:0] e);
    sb_exp.push_back(e);
    sb_tag.push_back(tag);
    compare_head();
  endtask

  // One clock cycle: drive inputs just after the edge, sample mid-cycle.
  task automatic step(input string tag, input logic [5:0] o, input logic mr,
                      input logic z, input logic [15:0] e);
    op = o;
    mem_ready = mr;
    zero = z;
    sb_exp.push_back(e);
    sb_tag.push_back(tag);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_ready = 1'b1;
    #3;
    check_now("rst_hold", E_RST);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("lw_fetch",  OP_LW, 1, 0, E_FRDY);
    step("lw_decode", OP_LW, 1, 0, E_DEC);
    step("lw_memadr", OP_LW, 1, 0, E_MEMADR);
    step("lw_memrd",  OP_LW, 1, 0, E_MEMRD);
    step("lw_memwb",  OP_LW, 1, 0, E_MEMWB);

    step("addi_fetch",  OP_ADDI, 1, 0, E_FRDY);
    step("addi_decode", OP_ADDI, 1, 0, E_DEC);
    step("addi_exec",   OP_ADDI, 1, 0, E_ADDIEX);
    step("addi_wb",     OP_ADDI, 1, 0, E_ADDIWB);

    step("j_fetch",  OP_J, 1, 0, E_FRDY);
    step("j_decode", OP_J, 1, 0, E_DEC);
    step("j_jump",   OP_J, 1, 0, E_JUMP);

`ifdef MC_CTRL_PERF_CNT_EN
    checks++;
    assert (cyc_cnt === 32'd12) else begin
      failures++;
      $error("FAIL perf_cyc observed=%0d expected=12", cyc_cnt);
    end
    checks++;
    assert (ret_cnt === 32'd3) else begin
      failures++;
      $error("FAIL perf_ret observed=%0d expected=3", ret_cnt);
    end
`endif

    step("r_fetch",  OP_RTYPE, 1, 0, E_FRDY);
    step("r_decode", OP_RTYPE, 1, 0, E_DEC);
    step("r_exec",   OP_RTYPE, 1, 0, E_EXEC);
    step("r_aluwb",  OP_RTYPE, 1, 0, E_ALUWB);

    step("beqt_fetch",  OP_BEQ, 1, 1, E_FRDY);
    step("beqt_decode", OP_BEQ, 1, 1, E_DEC);
    step("beqt_branch", OP_BEQ, 1, 1, E_BR_T);

    step("beqn_fetch",  OP_BEQ, 1, 0, E_FRDY);
    step("beqn_decode", OP_BEQ, 1, 0, E_DEC);
    step("beqn_branch", OP_BEQ, 1, 0, E_BR_N);

    step("beqn_back_fetch", 6'b111111, 1, 0, E_FRDY);
    step("ill_decode",      6'b111111, 1, 0, E_DECILL);
    step("ill_next_fetch",  OP_SW, 0, 0, E_FWAIT);

    step("sw_fetch_rdy", OP_SW, 1, 0, E_FRDY);
    step("sw_decode",    OP_SW, 1, 0, E_DEC);
    step("sw_memadr",    OP_SW, 1, 0, E_MEMADR);
    step("sw_memwr_w1",  OP_SW, 0, 0, E_MEMWR);
    step("sw_memwr_w2",  OP_SW, 0, 0, E_MEMWR);
    step("sw_memwr_w3",  OP_SW, 0, 0, E_MEMWR);
    step("sw_memwr_rdy", OP_SW, 1, 0, E_MEMWR);

    step("lw2_fetch",    OP_LW, 1, 0, E_FRDY);
    step("lw2_decode",   OP_LW, 1, 0, E_DEC);
    step("lw2_memadr",   OP_LW, 1, 0, E_MEMADR);
    step("lw2_memrd_w",  OP_LW, 0, 0, E_MEMRD);
    step("lw2_memrd",    OP_LW, 1, 0, E_MEMRD);
    step("lw2_memwb",    OP_LW, 1, 0, E_MEMWB);

    // Reset in the middle of a stalled store.
    step("rst_sw_fetch",  OP_SW, 1, 0, E_FRDY);
    step("rst_sw_decode", OP_SW, 1, 0, E_DEC);
    step("rst_sw_memadr", OP_SW, 1, 0, E_MEMADR);
    mem_ready = 1'b0;
    @(negedge clk);
    check_now("rst_memwr_pre", E_MEMWR);
    #1;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_now("rst_memwr_drop", E_RST);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_rel_wait1", OP_SW, 0, 0, E_FWAIT);
    step("rst_rel_wait2", OP_SW, 0, 0, E_FWAIT);
    step("rst_rel_fetch", OP_RTYPE, 1, 0, E_FRDY);
    step("rst_rel_decode", OP_RTYPE, 1, 0, E_DEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS main controller FSM.
- Sits directly upstream of the ALU function decoder and drives its 2-bit aluop input; also drives all datapath enables and muxes.
- Sequences fetch, decode, execute, memory and writeback over several cycles per instruction, stalling on a memory-ready handshake.

Parameters:
- STATE_W, 4, state register width; must hold 12 states.
- PERF_W, 32, width of optional performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction opcode, instr[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes current access this cycle
- zero  in  1  ALU zero flag
- pcen  out  1  PC load enable, equals pcwrite | (branch & zero)
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- alusrca  out  1  0=PC, 1=rs
- alusrcb  out  2  00=rt, 01=const 4, 10=signimm, 11=signimm<<2
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- iord  out  1  memory address: 0=PC, 1=ALUOut
- memtoreg  out  1  writeback from memory data
- regdst  out  1  destination register: 1=rd, 0=rt
- aluop  out  2  00=add, 01=sub, 10=use funct
- illegal_op  out  1  unsupported opcode seen in DECODE
- busy_fetch  out  1  high in FETCH state

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - State resets asynchronously to FETCH.
  - While rst_n=0, memwrite, irwrite, regwrite, pcen and illegal_op are forced to 0.
  - All other outputs take their FETCH values.
- Output style: Moore; outputs decode from the state register only, except pcen (uses zero) and the mem_ready-gated strobes.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
  - Next state by op: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP.
  - Any other op: illegal_op=1 for this cycle only, next state FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state: op=100011 -> MEMRD, else MEMWR.
- MEMRD: iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR:
  - iord=1, memwrite=1, held high until mem_ready.
  - Next state FETCH when mem_ready=1.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next state ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next state FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - pcen = zero. Next state FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, aluop=00. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state FETCH.
- Defaults: any output not listed for a state is 0.
- Unreachable encodings go to FETCH with all strobes 0.
- Latency with mem_ready tied high:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each low mem_ready cycle adds one cycle.
- Reset mid-instruction: abandons it immediately, with no partial write after rst_n deasserts.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- When defined, adds outputs cyc_cnt[PERF_W-1:0] and ret_cnt[PERF_W-1:0]:
  - cyc_cnt increments every cycle.
  - ret_cnt increments on each transition into FETCH from a non-FETCH state.
  - Both clear asynchronously on rst_n=0 and wrap modulo 2^PERF_W.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (12 states);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - aluop constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - alusrcb and pcsrc encodings.
- One natural sub-module: mc_ctrl_outdec, the pure combinational state-to-control-word decode. The state register and next-state logic stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-MEMWR with memwrite=1 -> memwrite drops to 0 immediately; after release state is FETCH, irwrite=0 until mem_ready=1.
- lw, op=100011, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 and memtoreg=1 only in cycle 5.
- R-type, op=000000 -> aluop=10 exactly in cycle 3; regdst=1, regwrite=1 in cycle 4.
- beq, op=000100:
  - zero=1 -> pcen=1, pcsrc=01, aluop=01 in cycle 3;
  - repeat with zero=0 -> pcen=0, back in FETCH in cycle 4.
- sw, op=101011, with mem_ready low for 3 cycles in MEMWR -> memwrite stays high for 4 cycles; total 7 cycles; no regwrite.
- Illegal op=111111 -> illegal_op=1 for exactly the DECODE cycle, FETCH next, no write strobes.
- With MC_CTRL_PERF_CNT_EN: lw + addi + j back-to-back, mem_ready=1 -> ret_cnt=3, cyc_cnt=12.
